// File: rtl/interval_capture_pkg.sv
// Shared definitions for the interval capture block: FSM encodings and default width.
package interval_capture_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/interval_capture_sat_counter.sv
// Saturating up-counter: clr beats inc, holds at all-ones instead of wrapping.
module sat_counter
  import interval_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX = '1;

  assign at_max = (cnt == MAX);

  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !at_max)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/interval_capture.sv
// Measures enabled cycles between start and stop; reports value/overflow with a valid strobe.
module interval_capture
  import interval_capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             overflow,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_e state, state_nxt;
  logic   clr, inc, at_max, ovf, report;

  sat_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .inc    (inc),
    .cnt    (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    inc       = 1'b0;
    report    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = MEASURE;
        clr       = 1'b1;
      end
      MEASURE: begin
        // stop outranks both a restart and the count in its own cycle
        if (stop) begin
          state_nxt = REPORT;
          report    = 1'b1;
        end else if (start) begin
          clr = 1'b1;
        end else begin
          inc = enable;
        end
      end
      REPORT: begin
        state_nxt = start ? MEASURE : IDLE;
        clr       = start;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky: an increment attempted while already saturated marks the run as overflowed.
  always_ff @(posedge clk) begin
    if (reset)                ovf <= 1'b0;
    else if (clr)             ovf <= 1'b0;
    else if (inc && at_max)   ovf <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= report;
      busy  <= (state_nxt == MEASURE);
      if (report) begin
        value    <= count;
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture: linear steps, hand-computed expectations.
module tb_interval_capture;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset, enable, start, stop;
  logic [W-1:0] value, count;
  logic         valid, overflow, busy;

  int compared = 0;
  int mismatched = 0;

  interval_capture #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .value    (value),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy),
    .count    (count)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int vl, input int ov,
                         input int b, input int c);
    chk({tag, ".value"},    32'(value),    32'(v));
    chk({tag, ".valid"},    32'(valid),    32'(vl));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".count"},    32'(count),    32'(c));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0;

    // 1: reset, then a lone stop in IDLE
    tick(2);
    reset = 1'b0;
    chk_out("rst", 0, 0, 0, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("idle_stop", 0, 0, 0, 0, 0);

    // 2: 10 enabled cycles
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t2_start", 0, 0, 0, 1, 0);
    enable = 1'b1; tick(10); enable = 1'b0;
    chk("t2_cnt", 32'(count), 10);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t2_rep", 10, 1, 0, 0, 10);
    tick();
    chk_out("t2_after", 10, 0, 0, 0, 10);

    // 3: 4 on, 2 off, 3 on; stop arrives with enable high and is not counted
    start = 1'b1; tick(); start = 1'b0;
    enable = 1'b1; tick(4);
    chk("t3_cnt4", 32'(count), 4);
    enable = 1'b0; tick(2);
    chk("t3_pause", 32'(count), 4);
    enable = 1'b1; tick(3);
    stop = 1'b1; tick(); stop = 1'b0; enable = 1'b0;
    chk_out("t3_rep", 7, 1, 0, 0, 7);

    // 4: saturation, then restart straight out of REPORT
    tick();
    start = 1'b1; tick(); start = 1'b0;
    enable = 1'b1; tick(40); enable = 1'b0;
    chk("t4_sat", 32'(count), 31);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t4_rep", 31, 1, 1, 0, 31);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t4_rearm", 31, 0, 1, 1, 0);
    enable = 1'b1; tick(3); enable = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t4_rep2", 3, 1, 0, 0, 3);
    tick();

    // 5: restart mid-run (with enable high) discards the partial count
    start = 1'b1; tick(); start = 1'b0;
    enable = 1'b1; tick(6);
    chk("t5_cnt6", 32'(count), 6);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t5_restart", 3, 0, 0, 1, 0);
    tick(3); enable = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t5_rep", 3, 1, 0, 0, 3);
    tick();
    chk("t5_single", 32'(valid), 0);

    // start&stop together: IDLE -> start wins; MEASURE -> stop wins
    start = 1'b1; stop = 1'b1; tick();
    chk_out("ss_idle", 3, 0, 0, 1, 0);
    enable = 1'b1; start = 1'b0; stop = 1'b0; tick(2); enable = 1'b0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_out("ss_meas", 2, 1, 0, 0, 2);
    tick();

    // 6: reset mid-run, reset also overrides a simultaneous start
    start = 1'b1; tick(); start = 1'b0;
    enable = 1'b1; tick(5); enable = 1'b0;
    chk("t6_cnt5", 32'(count), 5);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    chk_out("t6_rst", 0, 0, 0, 0, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t6_stop", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
